mul_arb: RTL and testbench
==========================

Name: mul_arb

Overview:
Two-requester arbiter and sequencer for the shared pipelined integer multiplier. It grants one requester per cycle, drives the multiplier's Execute-stage operands and Funct3, and tracks owner and tag through the multiplier latency. It steers each product back to its owner over a valid/ready response port, and stalls the multiplier when the owning requester cannot accept a result. Requester 0 is the integer MDU path (flushable). Requester 1 is a secondary unit, e.g. bitmanip/crypto, and is never flushed.

Parameters:
XLEN, 64, operand width; product is 2*XLEN.
LAT, 1, cycles from issue (Execute) to product valid on ProdM; legal range 1..4.
TAGW, 5, width of the requester tag carried alongside each operation.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
Req0, Req1  in  1  request valid per requester
Src0A, Src0B, Src1A, Src1B  in  XLEN  operands per requester
Funct30, Funct31  in  3  multiply type per requester (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU)
Tag0, Tag1  in  TAGW  requester tag
Gnt0, Gnt1  out  1  request accepted this cycle
Flush0  in  1  kill all requester-0 operations, issued or in flight
MulSrcAE, MulSrcBE  out  XLEN  operands to multiplier
MulFunct3E  out  3  multiply type to multiplier
MulStallM  out  1  hold multiplier pipeline registers
ProdM  in  2*XLEN  product from multiplier, aligned with head stage
Rsp0Valid, Rsp1Valid  out  1  product available for owner
Rsp0Ready, Rsp1Ready  in  1  owner accepts product
Rsp0Prod, Rsp1Prod  out  2*XLEN  product (ProdM passthrough)
Rsp0Tag, Rsp1Tag  out  TAGW  tag of returned operation

Behaviour:
- Tracking pipe: LAT stages of {Valid, Owner, Tag}. Stage LAT-1 is the head and is aligned with ProdM.
- MulStallM = HeadValid & ~RspReady[HeadOwner]. This is combinational from Ready.
- RspNValid = HeadValid & (HeadOwner==N). RspNProd/RspNTag are driven from ProdM/HeadTag regardless of valid.
- When MulStallM=0, the pipe shifts every cycle. Stage 0 loads {granted, owner, tag}, or Valid=0 if nothing is granted.
- When MulStallM=1, the pipe holds, and Gnt0=Gnt1=0.
- Arbitration is round-robin through LastGnt.
  - Single request: that requester is granted.
  - Both requesting: grant the requester that was not LastGnt.
  - LastGnt updates only on a grant.
  - Reset sets LastGnt=1, so requester 0 wins the first tie.
- GntN is combinational from ReqN, Flush0 and stall. A request must be held until granted. Requesters may not drop a request once raised, except requester 0 under Flush0.
- Mul operand mux:
  - Drives the granted requester's Src/Funct3.
  - With no grant, drives zeros and Funct3=000 to avoid toggle.
- Flush0:
  - Clears Valid in every stage with Owner=0, in the same cycle it is applied to the registered state.
  - Suppresses Gnt0 that cycle.
  - If the head is owned by requester 0, Rsp0Valid is forced 0 and MulStallM is forced 0 that cycle.
  - Requester-1 entries are untouched.
- Latency: a grant in cycle t gives earliest RspValid in cycle t+LAT. Back-to-back grants give one response per cycle when unstalled.
- Reset: all Valid=0, LastGnt=1. All Gnt/RspValid/MulStallM are 0 the following cycle. In-flight operations are discarded, with no response.
- A simultaneous grant and head handshake in the same cycle is legal: full throughput.

Optional Feature:
MUL_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins ties, and LastGnt is not implemented. Requester 1 can starve; this is intended for latency-critical integer pipelines.
- Undefined: round-robin as above.

Decomposition:
- Package mul_arb_pkg:
  - typedef enum logic {OWN_IEU=0, OWN_AUX=1} mul_owner_t.
  - Funct3 constants MUL_F3_MUL/MULH/MULHSU/MULHU.
  - Struct mul_track_t {Valid, Owner, Tag}.
- One sub-module, rr_arb2: 2-way round-robin/fixed-priority grant logic holding LastGnt and honouring MUL_ARB_FIXED_PRIO_EN.

Test Plan:
1. Single issue, LAT=1:
   - Stimulus: Req0=1, Src0A=-3, Src0B=5, Funct30=001, Tag0=7.
   - Response: Gnt0 in cycle 0; Rsp0Valid in cycle 1 with Rsp0Tag=7, and Rsp0Prod equal to ProdM from the multiplier model (upper half all ones).
2. Contention:
   - Stimulus: Req0=Req1=1 held for 4 grants.
   - Response: grants alternate 0,1,0,1 starting with 0 after reset; responses return in the same order, one per cycle.
3. Backpressure:
   - Stimulus: head owned by 1, Rsp1Ready=0 for 3 cycles.
   - Response: MulStallM=1 and no grants for 3 cycles; Rsp1Valid/Tag held stable; release yields the response, then the pipe resumes.
4. Flush:
   - Stimulus: LAT=2 with ops 0,1 in flight; Flush0 pulsed with Req0 high.
   - Response: no Gnt0 that cycle; the requester-0 response is never emitted; the requester-1 response is still delivered with its tag.
5. Reset mid-operation:
   - Stimulus: reset asserted with 2 ops in flight.
   - Response: no RspValid afterwards; the first tie after reset grants requester 0.
6. MUL_ARB_FIXED_PRIO_EN defined:
   - Stimulus: Req0=Req1=1 for 5 cycles.
   - Response: Gnt0 every cycle, Gnt1=0.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types for the multiplier arbiter: owner encoding, Funct3 codes, tracking entry.
// Optional MUL_ARB_FIXED_PRIO_EN selects fixed priority in rr_arb2.
package mul_arb_pkg;

  typedef enum logic {
    OWN_IEU = 1'b0,
    OWN_AUX = 1'b1
  } mul_owner_t;

  localparam logic [2:0] MUL_F3_MUL    = 3'b000;
  localparam logic [2:0] MUL_F3_MULH   = 3'b001;
  localparam logic [2:0] MUL_F3_MULHSU = 3'b010;
  localparam logic [2:0] MUL_F3_MULHU  = 3'b011;

  // Tag field is sized for the widest supported TAGW; narrower tags are zero-extended.
  localparam int unsigned MUL_TAGW_MAX = 16;

  typedef struct packed {
    logic                    valid;
    mul_owner_t              owner;
    logic [MUL_TAGW_MAX-1:0] tag;
  } mul_track_t;

  function automatic mul_track_t mul_kill_ieu(input mul_track_t t, input logic flush0);
    mul_kill_ieu = t;
    if (flush0 && (t.owner == OWN_IEU)) mul_kill_ieu.valid = 1'b0;
  endfunction

endpackage

// File: rtl/mul_arb_rr.sv
// rr_arb2: two-way grant logic. Round-robin on LastGnt by default;
// fixed priority to requester 0 when MUL_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import mul_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = req0;
    gnt1 = req1 & ~req0;
  end
`else
  mul_owner_t last_gnt;

  always_ff @(posedge clk) begin
    if (reset)     last_gnt <= OWN_AUX;
    else if (gnt0) last_gnt <= OWN_IEU;
    else if (gnt1) last_gnt <= OWN_AUX;
  end

  // On a tie, the requester that did not win last time goes first.
  always_comb begin
    gnt0 = req0 & (~req1 | (last_gnt == OWN_AUX));
    gnt1 = req1 & ~gnt0;
  end
`endif

endmodule

// File: rtl/mul_arb.sv
// Two-requester arbiter/sequencer for the shared pipelined multiplier.
// Tracks owner/tag through LAT stages; MUL_ARB_FIXED_PRIO_EN selects fixed priority.
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned LAT  = 1,
  parameter int unsigned TAGW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [XLEN-1:0]   Src0A,
  input  logic [XLEN-1:0]   Src0B,
  input  logic [XLEN-1:0]   Src1A,
  input  logic [XLEN-1:0]   Src1B,
  input  logic [2:0]        Funct30,
  input  logic [2:0]        Funct31,
  input  logic [TAGW-1:0]   Tag0,
  input  logic [TAGW-1:0]   Tag1,
  output logic              Gnt0,
  output logic              Gnt1,
  input  logic              Flush0,
  output logic [XLEN-1:0]   MulSrcAE,
  output logic [XLEN-1:0]   MulSrcBE,
  output logic [2:0]        MulFunct3E,
  output logic              MulStallM,
  input  logic [2*XLEN-1:0] ProdM,
  output logic              Rsp0Valid,
  output logic              Rsp1Valid,
  input  logic              Rsp0Ready,
  input  logic              Rsp1Ready,
  output logic [2*XLEN-1:0] Rsp0Prod,
  output logic [2*XLEN-1:0] Rsp1Prod,
  output logic [TAGW-1:0]   Rsp0Tag,
  output logic [TAGW-1:0]   Rsp1Tag
);

  mul_track_t track_q [LAT];
  mul_track_t track_d [LAT];
  mul_track_t kept    [LAT];
  mul_track_t head;
  mul_track_t new_ent;
  logic       head_live;
  logic       head_rdy;
  logic       stall;
  logic       g0;
  logic       g1;

  // A flushed requester-0 head is treated as already gone, so it can never stall.
  always_comb begin
    head      = track_q[LAT-1];
    head_live = mul_kill_ieu(head, Flush0).valid;
    head_rdy  = (head.owner == OWN_AUX) ? Rsp1Ready : Rsp0Ready;
    stall     = head_live & ~head_rdy;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (Req0 & ~Flush0 & ~stall),
    .req1  (Req1 & ~stall),
    .gnt0  (g0),
    .gnt1  (g1)
  );

  always_comb begin
    new_ent       = '0;
    new_ent.valid = g0 | g1;
    new_ent.owner = g1 ? OWN_AUX : OWN_IEU;
    if (g1) new_ent.tag[TAGW-1:0] = Tag1;
    else    new_ent.tag[TAGW-1:0] = Tag0;
  end

  // Flush kills requester-0 entries whether the pipe shifts or holds.
  always_comb begin
    for (int unsigned i = 0; i < LAT; i++) begin
      kept[i] = mul_kill_ieu(track_q[i], Flush0);
    end
    track_d = kept;
    if (!stall) begin
      track_d[0] = new_ent;
      for (int unsigned i = 1; i < LAT; i++) begin
        track_d[i] = kept[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) track_q[i] <= '0;
    end else begin
      track_q <= track_d;
    end
  end

  always_comb begin
    MulSrcAE   = '0;
    MulSrcBE   = '0;
    MulFunct3E = MUL_F3_MUL;
    if (g0) begin
      MulSrcAE   = Src0A;
      MulSrcBE   = Src0B;
      MulFunct3E = Funct30;
    end else if (g1) begin
      MulSrcAE   = Src1A;
      MulSrcBE   = Src1B;
      MulFunct3E = Funct31;
    end
  end

  always_comb begin
    Gnt0      = g0;
    Gnt1      = g1;
    MulStallM = stall;
    Rsp0Valid = head_live & (head.owner == OWN_IEU);
    Rsp1Valid = head_live & (head.owner == OWN_AUX);
    Rsp0Prod  = ProdM;
    Rsp1Prod  = ProdM;
    Rsp0Tag   = head.tag[TAGW-1:0];
    Rsp1Tag   = head.tag[TAGW-1:0];
  end

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: queue-based reference model plus directed literal checks.
module tb_mul_arb;

  localparam int XLEN = 64;
  localparam int LAT  = 2;
  localparam int TAGW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              Req0, Req1, Flush0;
  logic [XLEN-1:0]   Src0A, Src0B, Src1A, Src1B;
  logic [2:0]        Funct30, Funct31;
  logic [TAGW-1:0]   Tag0, Tag1;
  logic              Gnt0, Gnt1, MulStallM;
  logic [XLEN-1:0]   MulSrcAE, MulSrcBE;
  logic [2:0]        MulFunct3E;
  logic [2*XLEN-1:0] ProdM;
  logic              Rsp0Valid, Rsp1Valid, Rsp0Ready, Rsp1Ready;
  logic [2*XLEN-1:0] Rsp0Prod, Rsp1Prod;
  logic [TAGW-1:0]   Rsp0Tag, Rsp1Tag;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mul_arb #(.XLEN(XLEN), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .Req0(Req0), .Req1(Req1),
    .Src0A(Src0A), .Src0B(Src0B), .Src1A(Src1A), .Src1B(Src1B),
    .Funct30(Funct30), .Funct31(Funct31), .Tag0(Tag0), .Tag1(Tag1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Flush0(Flush0),
    .MulSrcAE(MulSrcAE), .MulSrcBE(MulSrcBE), .MulFunct3E(MulFunct3E),
    .MulStallM(MulStallM), .ProdM(ProdM),
    .Rsp0Valid(Rsp0Valid), .Rsp1Valid(Rsp1Valid),
    .Rsp0Ready(Rsp0Ready), .Rsp1Ready(Rsp1Ready),
    .Rsp0Prod(Rsp0Prod), .Rsp1Prod(Rsp1Prod),
    .Rsp0Tag(Rsp0Tag), .Rsp1Tag(Rsp1Tag)
  );

  function automatic logic [127:0] mulref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] f);
    logic [127:0] ae, be;
    ae = (f == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
    be = (f == 3'b010 || f == 3'b011) ? {64'b0, b} : {{64{b[63]}}, b};
    return ae * be;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Environment multiplier: LAT-stage pipe that holds on MulStallM.
  logic [127:0] mp [LAT];
  always @(posedge clk) begin
    if (!MulStallM) begin
      mp[0] <= mulref(MulSrcAE, MulSrcBE, MulFunct3E);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign ProdM = mp[LAT-1];

  // Reference model: in-order queue of outstanding ops, each aged by unstalled cycles.
  typedef struct {
    bit              owner;
    logic [TAGW-1:0] tag;
    logic [127:0]    prod;
    int              age;
  } ent_t;

  ent_t q[$];
  bit   last_m = 1'b1;
`ifdef MUL_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  initial begin
    forever begin
      bit hv, ho, eff, es, e0, e1, g0, g1, rst, fl;
      ent_t ne;
      ent_t nq[$];
      @(negedge clk);
      hv  = (q.size() > 0) && (q[0].age == LAT-1);
      ho  = hv ? q[0].owner : 1'b0;
      eff = hv && !(Flush0 && !ho);
      es  = eff && !(ho ? Rsp1Ready : Rsp0Ready);
      e0  = Req0 && !Flush0 && !es;
      e1  = Req1 && !es;
      if (e0 && e1) begin
        g0 = FIXED ? 1'b1 : last_m;
        g1 = !g0;
      end else begin
        g0 = e0;
        g1 = e1;
      end
      chk("gnt0", 128'(Gnt0), 128'(g0));
      chk("gnt1", 128'(Gnt1), 128'(g1));
      chk("stall", 128'(MulStallM), 128'(es));
      chk("rsp0valid", 128'(Rsp0Valid), 128'(eff && !ho));
      chk("rsp1valid", 128'(Rsp1Valid), 128'(eff && ho));
      chk("srca", 128'(MulSrcAE), g0 ? 128'(Src0A) : g1 ? 128'(Src1A) : 128'(0));
      chk("srcb", 128'(MulSrcBE), g0 ? 128'(Src0B) : g1 ? 128'(Src1B) : 128'(0));
      chk("funct3", 128'(MulFunct3E), g0 ? 128'(Funct30) : g1 ? 128'(Funct31) : 128'(0));
      if (eff && !ho) begin
        chk("rsp0tag", 128'(Rsp0Tag), 128'(q[0].tag));
        chk("rsp0prod", Rsp0Prod, q[0].prod);
      end
      if (eff && ho) begin
        chk("rsp1tag", 128'(Rsp1Tag), 128'(q[0].tag));
        chk("rsp1prod", Rsp1Prod, q[0].prod);
      end
      ne.owner = g1;
      ne.tag   = g1 ? Tag1 : Tag0;
      ne.prod  = g1 ? mulref(Src1A, Src1B, Funct31) : mulref(Src0A, Src0B, Funct30);
      ne.age   = 0;
      rst = reset;
      fl  = Flush0;
      @(posedge clk);
      if (rst) begin
        q.delete();
        last_m = 1'b1;
      end else begin
        if (!es && eff) void'(q.pop_front());
        if (fl) begin
          nq.delete();
          foreach (q[i]) if (q[i].owner) nq.push_back(q[i]);
          q = nq;
        end
        if (!es) begin
          foreach (q[i]) q[i].age++;
          if (g0 || g1) q.push_back(ne);
        end
        if (g0) last_m = 1'b0;
        else if (g1) last_m = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'h8000_0000_0000_0000;
      1: return '1;
      2: return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [4:0] pat;
    bit sg0, sg1, sf;
    reset = 1'b1; Req0 = 0; Req1 = 0; Flush0 = 0;
    Src0A = '0; Src0B = '0; Src1A = '0; Src1B = '0;
    Funct30 = '0; Funct31 = '0; Tag0 = '0; Tag1 = '0;
    Rsp0Ready = 1; Rsp1Ready = 1;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_stall", 128'(MulStallM), 128'(0));
    chk("reset_rsp", 128'(Rsp0Valid | Rsp1Valid), 128'(0));

    // Single MULH issue: -3 * 5, product upper half all ones.
    cyc();
    Req0 = 1; Src0A = 64'hFFFF_FFFF_FFFF_FFFD; Src0B = 64'd5; Funct30 = 3'b001; Tag0 = 5'd7;
    @(negedge clk);
    chk("t1_gnt0", 128'(Gnt0), 128'(1));
    cyc();
    Req0 = 0;
    @(negedge clk);
    chk("t1_early", 128'(Rsp0Valid), 128'(0));
    cyc();
    @(negedge clk);
    chk("t1_valid", 128'(Rsp0Valid), 128'(1));
    chk("t1_tag", 128'(Rsp0Tag), 128'(7));
    chk("t1_prod", Rsp0Prod, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);

    // Contention from reset.
    cyc(); reset = 1; cyc(); reset = 0;
`ifdef MUL_ARB_FIXED_PRIO_EN
    pat = 5'b11111;
`else
    pat = 5'b10101;
`endif
    Req0 = 1; Req1 = 1; Src0A = 64'd3; Src0B = 64'd4; Src1A = 64'd6; Src1B = 64'd7;
    for (int k = 0; k < 5; k++) begin
      Tag0 = 5'(k); Tag1 = 5'(k + 16);
      @(negedge clk);
      chk("t2_gnt0", 128'(Gnt0), 128'(pat[k]));
      chk("t2_gnt1", 128'(Gnt1), 128'(!pat[k]));
      cyc();
    end
    Req0 = 0; Req1 = 0;
    repeat (LAT + 2) cyc();

    // Backpressure on requester 1.
    Req1 = 1; Tag1 = 5'd9; Rsp1Ready = 0;
    cyc();
    Req1 = 0; Req0 = 1; Tag0 = 5'd3;
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall", 128'(MulStallM), 128'(1));
      chk("t3_nogrant", 128'(Gnt0 | Gnt1), 128'(0));
      chk("t3_valid", 128'(Rsp1Valid), 128'(1));
      chk("t3_tag", 128'(Rsp1Tag), 128'(9));
      cyc();
    end
    Rsp1Ready = 1;
    @(negedge clk);
    chk("t3_release_valid", 128'(Rsp1Valid), 128'(1));
    chk("t3_release_stall", 128'(MulStallM), 128'(0));
    chk("t3_release_gnt0", 128'(Gnt0), 128'(1));
    cyc();
    Req0 = 0;
    repeat (LAT + 2) cyc();

    // Flush with ops 0 and 1 in flight.
    Req0 = 1; Tag0 = 5'd11;
    cyc();
    Req0 = 0; Req1 = 1; Tag1 = 5'd12;
    cyc();
    Req1 = 0; Req0 = 1; Tag0 = 5'd13; Flush0 = 1;
    @(negedge clk);
    chk("t4_nogrant0", 128'(Gnt0), 128'(0));
    chk("t4_rsp0", 128'(Rsp0Valid), 128'(0));
    chk("t4_stall", 128'(MulStallM), 128'(0));
    cyc();
    Flush0 = 0;
    @(negedge clk);
    chk("t4_rsp1", 128'(Rsp1Valid), 128'(1));
    chk("t4_rsp1tag", 128'(Rsp1Tag), 128'(12));
    cyc();
    Req0 = 0;
    repeat (LAT + 2) cyc();

    // Reset with ops in flight.
    Req0 = 1; Tag0 = 5'd20;
    cyc();
    Req0 = 0; Req1 = 1; Tag1 = 5'd21; reset = 1;
    cyc();
    reset = 0; Req1 = 0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      chk("t5_norsp", 128'(Rsp0Valid | Rsp1Valid), 128'(0));
      cyc();
    end
    Req0 = 1; Req1 = 1;
    @(negedge clk);
    chk("t5_tie_gnt0", 128'(Gnt0), 128'(1));
    chk("t5_tie_gnt1", 128'(Gnt1), 128'(0));
    cyc();
    Req0 = 0;
    cyc();
    Req1 = 0;
    repeat (LAT + 2) cyc();

    // Randomized traffic respecting the request-hold rule.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sg0 = Gnt0; sg1 = Gnt1; sf = Flush0;
      cyc();
      reset     = ($urandom_range(0, 199) == 0);
      Flush0    = ($urandom_range(0, 19) == 0);
      Rsp0Ready = ($urandom_range(0, 9) < 7);
      Rsp1Ready = ($urandom_range(0, 9) < 7);
      if (!Req0 || sg0 || (sf && $urandom_range(0, 1) == 1)) begin
        Req0 = ($urandom_range(0, 2) != 0);
        Src0A = rnd64(); Src0B = rnd64();
        Funct30 = 3'($urandom_range(0, 3)); Tag0 = 5'($urandom_range(0, 31));
      end
      if (!Req1 || sg1) begin
        Req1 = ($urandom_range(0, 2) != 0);
        Src1A = rnd64(); Src1B = rnd64();
        Funct31 = 3'($urandom_range(0, 3)); Tag1 = 5'($urandom_range(0, 31));
      end
    end
    reset = 0; Flush0 = 0; Req0 = 0; Req1 = 0; Rsp0Ready = 1; Rsp1Ready = 1;
    repeat (LAT + 4) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
